// File: rtl/serial_kbd_rx.sv
// rtl/serial_kbd_rx.sv - 8N1 serial keyboard receiver with byte FIFO and IRQ/IACK/IEND host handshake
module serial_kbd_rx #(
  parameter int CLKS_PER_BIT   = 10417,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_SERIAL_RX,
  output logic [7:0] OUT_DATA,
  output logic       OUT_IRQ,
  input  logic       IN_IACK,
  input  logic       IN_IEND,
  output logic       OUT_FRAME_ERR,
  output logic       OUT_OVERRUN
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0]          HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]          LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
  localparam logic [FIFO_ADDR_BITS:0]   FULL_CNT = (FIFO_ADDR_BITS + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_BITS:0]   OCC_ONE  = (FIFO_ADDR_BITS + 1)'(1);
  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE  = FIFO_ADDR_BITS'(1);

  // receive FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // host handshake FSM encoding
  localparam logic [0:0] H_IDLE = 1'b0;
  localparam logic [0:0] H_ACK  = 1'b1;

  // synchronizer and edge history
  logic sync1_q, rxs_q, rxs_prev_q;

  // receiver state
  logic [1:0]       rx_state_q, rx_state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push;

  // FIFO state
  logic [7:0]                mem_q [DEPTH];
  logic [7:0]                mem_d [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_BITS:0]   count_q, count_d;
  logic                      overrun_q, overrun_d;
  logic                      full, empty, pop, push_ok;

  // host handshake state
  logic [0:0] h_state_q, h_state_d;
  logic [7:0] data_q, data_d;
  logic       irq;

  // receive FSM: falling-edge start detect, mid-bit sampling, stop-bit validation
  always_comb begin
    rx_state_d  = rx_state_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        // needs a real 1->0 edge, so a held-low break line never restarts a frame
        if (rxs_prev_q && !rxs_q) begin
          rx_state_d = S_START;
          cyc_cnt_d  = '0;
        end
      end
      S_START: begin
        if (cyc_cnt_q == HALF_CNT) begin
          if (!rxs_q) begin
            rx_state_d = S_DATA;
            cyc_cnt_d  = '0;
            bit_cnt_d  = '0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cyc_cnt_q == LAST_CNT) begin
          cyc_cnt_d = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = S_STOP;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cyc_cnt_q == LAST_CNT) begin
          if (rxs_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          rx_state_d = S_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: pop is applied before push, so a full FIFO accepts a byte when popped together
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = (h_state_q == H_ACK) && IN_IEND;
    push_ok = push && (!full || pop);

    overrun_d = overrun_q | (push && full && !pop);

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
    end

    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase
  end

  // host handshake: IACK latches the FIFO head, IEND releases it
  always_comb begin
    irq       = (h_state_q == H_IDLE) && !empty;
    h_state_d = h_state_q;
    data_d    = data_q;
    case (h_state_q)
      H_IDLE: begin
        if (irq && IN_IACK) begin
          h_state_d = H_ACK;
          data_d    = mem_q[rd_ptr_q];
        end
      end
      H_ACK: begin
        if (IN_IEND) begin
          h_state_d = H_IDLE;
        end
      end
      default: h_state_d = H_IDLE;
    endcase
  end

  // state registers; reset also aborts any frame in progress without push or error
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      rx_state_q  <= S_IDLE;
      bit_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      h_state_q   <= H_IDLE;
      data_q      <= '0;
    end else begin
      sync1_q     <= IN_SERIAL_RX;
      rxs_q       <= sync1_q;
      rxs_prev_q  <= rxs_q;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      h_state_q   <= h_state_d;
      data_q      <= data_d;
    end
  end

  assign OUT_DATA      = data_q;
  assign OUT_IRQ       = irq;
  assign OUT_FRAME_ERR = frame_err_q;
  assign OUT_OVERRUN   = overrun_q;

endmodule

// File: tb/tb_serial_kbd_rx.sv
// tb/tb_serial_kbd_rx.sv - self-checking bench for serial_kbd_rx with a queue-based host model
module tb_serial_kbd_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       iack;
  logic       iend;
  logic [7:0] out_data;
  logic       out_irq;
  logic       out_ferr;
  logic       out_ovr;

  serial_kbd_rx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_BITS(2)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .IN_SERIAL_RX (rx),
    .OUT_DATA     (out_data),
    .OUT_IRQ      (out_irq),
    .IN_IACK      (iack),
    .IN_IEND      (iend),
    .OUT_FRAME_ERR(out_ferr),
    .OUT_OVERRUN  (out_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_err;
    logic       exp_irq;
    logic [7:0] exp_data;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         err_seen = 0;
  logic [7:0] q[$];
  logic       ovr_m;
  logic [7:0] data_m;

  // count cycles on which the frame-error pulse is high
  always @(negedge clk) begin
    if (out_ferr === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive one 8N1 frame; optionally keep the line low after the stop bit (break)
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int tail_low,
                            output logic irq_pre_stop);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    irq_pre_stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == 9) irq_pre_stop = out_irq;
      repeat (CPB) tick();
    end
    if (tail_low > 0) begin
      rx = 1'b0;
      repeat (tail_low) tick();
    end
    rx = 1'b1;
    repeat (4) tick();
  endtask

  // reference: a good frame is queued unless four bytes already wait, else it is lost
  task automatic model_rx(input logic [7:0] d, input logic stop_bit);
    if (stop_bit) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ovr_m = 1'b1;
    end
  endtask

  // full IACK/IEND service cycle of the oldest queued byte
  task automatic service(input string tag);
    logic [7:0] exp;
    chk_bit({tag, "_irq_pre"}, out_irq, 1'b1);
    if (q.size() == 0) return;
    exp = q.pop_front();
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk_byte({tag, "_data"}, out_data, exp);
    chk_bit({tag, "_irq_in_ack"}, out_irq, 1'b0);
    tick();
    chk_byte({tag, "_data_held"}, out_data, exp);
    iend = 1'b1;
    tick();
    iend = 1'b0;
    chk_bit({tag, "_irq_post"}, out_irq, q.size() > 0);
    chk_byte({tag, "_data_after_iend"}, out_data, exp);
    data_m = exp;
  endtask

  vec_t       tbl [6];
  logic       pre;
  int         e0;
  logic [7:0] rd;
  logic       rsb;
  int         act;

  initial begin
    tbl[0] = '{8'h31, 1'b1, 0, 1'b1, 8'h31};
    tbl[1] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF};
    tbl[3] = '{8'h55, 1'b0, 1, 1'b0, 8'hFF};
    tbl[4] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5};
    tbl[5] = '{8'h80, 1'b0, 1, 1'b0, 8'hA5};

    rx = 1'b1; iack = 1'b0; iend = 1'b0; rst = 1'b1;
    ovr_m = 1'b0; data_m = 8'h00;
    repeat (3) tick();
    chk_byte("reset_data", out_data, 8'h00);
    chk_bit("reset_irq", out_irq, 1'b0);
    chk_bit("reset_ferr", out_ferr, 1'b0);
    chk_bit("reset_ovr", out_ovr, 1'b0);
    rst = 1'b0;
    repeat (4) tick();

    // table of single frames, each serviced when it produced a byte
    for (int i = 0; i < 6; i++) begin
      e0 = err_seen;
      send_frame(tbl[i].data, tbl[i].stop, 0, pre);
      model_rx(tbl[i].data, tbl[i].stop);
      chk_int("tbl_ferr_cycles", err_seen - e0, tbl[i].exp_err);
      chk_bit("tbl_irq", out_irq, tbl[i].exp_irq);
      if (tbl[i].exp_irq) begin
        chk_bit("tbl_irq_before_stop", pre, 1'b0);
        service("tbl");
      end
      chk_byte("tbl_out_data", out_data, tbl[i].exp_data);
      chk_bit("tbl_ovr", out_ovr, 1'b0);
    end

    // short low glitch is rejected
    e0 = err_seen;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    chk_bit("glitch_irq", out_irq, 1'b0);
    chk_int("glitch_ferr", err_seen - e0, 0);

    // bad stop followed by a break: one error, no extra frame
    e0 = err_seen;
    send_frame(8'h55, 1'b0, 3 * CPB, pre);
    chk_int("break_ferr_cycles", err_seen - e0, 1);
    chk_bit("break_irq", out_irq, 1'b0);

    // receiver recovered; exercise ignored handshake combinations
    send_frame(8'h5A, 1'b1, 0, pre);
    model_rx(8'h5A, 1'b1);
    chk_bit("after_break_irq", out_irq, 1'b1);
    iend = 1'b1; tick(); iend = 1'b0;
    chk_bit("iend_in_idle_ignored", out_irq, 1'b1);
    iack = 1'b1; iend = 1'b1; tick(); iack = 1'b0; iend = 1'b0;
    chk_bit("iack_iend_together_irq", out_irq, 1'b0);
    chk_byte("iack_iend_together_data", out_data, 8'h5A);
    iack = 1'b1; tick(); iack = 1'b0;
    chk_bit("iack_in_ack_ignored", out_irq, 1'b0);
    chk_byte("iack_in_ack_data", out_data, 8'h5A);
    iend = 1'b1; tick(); iend = 1'b0;
    void'(q.pop_front());
    data_m = 8'h5A;
    chk_bit("after_iend_empty_irq", out_irq, 1'b0);
    chk_byte("after_iend_data_held", out_data, 8'h5A);
    iack = 1'b1; tick(); iack = 1'b0; tick();
    chk_bit("iack_without_irq", out_irq, 1'b0);
    send_frame(8'h66, 1'b1, 0, pre);
    model_rx(8'h66, 1'b1);
    chk_bit("iack_without_irq_ignored", out_irq, 1'b1);
    service("s66");

    // byte arriving during H_ACK waits until IEND
    send_frame(8'h31, 1'b1, 0, pre);
    model_rx(8'h31, 1'b1);
    iack = 1'b1; tick(); iack = 1'b0;
    chk_byte("hack_data31", out_data, 8'h31);
    send_frame(8'h32, 1'b1, 0, pre);
    model_rx(8'h32, 1'b1);
    chk_bit("hack_irq_held_low", out_irq, 1'b0);
    chk_byte("hack_data_still31", out_data, 8'h31);
    iend = 1'b1; tick(); iend = 1'b0;
    void'(q.pop_front());
    chk_bit("hack_irq_after_iend", out_irq, 1'b1);
    service("hack32");

    // overrun: five bytes into a four-deep FIFO
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h31 + 8'(k), 1'b1, 0, pre);
      model_rx(8'h31 + 8'(k), 1'b1);
    end
    chk_bit("ovr_set", out_ovr, 1'b1);
    for (int k = 0; k < 4; k++) service("ovr");
    chk_bit("ovr_drained_irq", out_irq, 1'b0);
    chk_bit("ovr_sticky", out_ovr, 1'b1);

    // reset in the middle of bit 3 of a frame
    e0 = err_seen;
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (3 * CPB + CPB / 2) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    q.delete(); ovr_m = 1'b0; data_m = 8'h00;
    repeat (3 * CPB) tick();
    chk_byte("midreset_data", out_data, 8'h00);
    chk_bit("midreset_irq", out_irq, 1'b0);
    chk_bit("midreset_ovr", out_ovr, 1'b0);
    chk_bit("midreset_ferr_now", out_ferr, 1'b0);
    chk_int("midreset_ferr", err_seen - e0, 0);
    send_frame(8'h41, 1'b1, 0, pre);
    model_rx(8'h41, 1'b1);
    service("after_reset41");

    // randomized traffic against the queue model
    for (int it = 0; it < 30; it++) begin
      act = int'($urandom_range(0, 3));
      if (act < 3) begin
        rd  = 8'($urandom_range(0, 255));
        rsb = ($urandom_range(0, 4) != 0);
        e0  = err_seen;
        send_frame(rd, rsb, 0, pre);
        model_rx(rd, rsb);
        chk_int("rnd_ferr", err_seen - e0, rsb ? 0 : 1);
      end else if (q.size() > 0) begin
        service("rnd");
      end else begin
        iack = 1'b1; tick(); iack = 1'b0; tick();
        chk_byte("rnd_data_hold", out_data, data_m);
      end
      chk_bit("rnd_irq", out_irq, q.size() > 0);
      chk_bit("rnd_ovr", out_ovr, ovr_m);
    end
    while (q.size() > 0) service("drain");
    chk_bit("final_irq", out_irq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
